// File: rtl/mc_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit_pkg
// Purpose  : Shared state codes, opcode constants and datapath select
//            encodings for the multi-cycle control unit.
// Revision : 1.0  initial release
// ============================================================================
package mc_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IF       = 3'b000,
        ST_ID       = 3'b001,
        ST_MEM_ADDR = 3'b010,
        ST_MEM      = 3'b011,
        ST_WB_LW    = 3'b100,
        ST_EXE_BEQ  = 3'b101,
        ST_EXE_R    = 3'b110,
        ST_WB_R     = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SLT  = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

    // Opcodes that go through the ALU execute / register write-back pair
    function automatic logic is_r_class(input logic [5:0] op);
        return (op == OP_ADD)  || (op == OP_SUB) || (op == OP_ADDI) ||
               (op == OP_OR)   || (op == OP_AND) || (op == OP_ORI)  ||
               (op == OP_SLL)  || (op == OP_MOVE) || (op == OP_SLT);
    endfunction

    // ALU operation for the R-class group; immediate forms reuse the base op
    function automatic logic [2:0] alu_op_for(input logic [5:0] op);
        logic [2:0] alu;
        alu = ALU_ADD;
        case (op)
            OP_SUB:         alu = ALU_SUB;
            OP_SLL:         alu = ALU_SLL;
            OP_OR, OP_ORI:  alu = ALU_OR;
            OP_AND:         alu = ALU_AND;
            OP_SLT:         alu = ALU_SLT;
            default:        alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_unit_next_state.sv
`default_nettype none
// ============================================================================
// Module   : mc_next_state
// Purpose  : Combinational next-state function of the multi-cycle control
//            unit.
// Revision : 1.0  initial release
// ============================================================================
module mc_next_state
    import mc_control_unit_pkg::*;
(
    input  state_t     state,
    input  logic       halted,
    input  logic [5:0] opcode,
    output state_t     next_state
);

    // Sequence each instruction class; a halted core parks in fetch
    always_comb begin
        next_state = ST_IF;
        if (!halted) begin
            case (state)
                ST_IF:       next_state = ST_ID;
                ST_ID: begin
                    if (is_r_class(opcode))                          next_state = ST_EXE_R;
                    else if (opcode == OP_BEQ)                       next_state = ST_EXE_BEQ;
                    else if ((opcode == OP_SW) || (opcode == OP_LW)) next_state = ST_MEM_ADDR;
                    else                                             next_state = ST_IF;
                end
                ST_EXE_R:    next_state = ST_WB_R;
                ST_WB_R:     next_state = ST_IF;
                ST_EXE_BEQ:  next_state = ST_IF;
                ST_MEM_ADDR: next_state = ST_MEM;
                ST_MEM:      next_state = (opcode == OP_LW) ? ST_WB_LW : ST_IF;
                ST_WB_LW:    next_state = ST_IF;
                default:     next_state = ST_IF;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit
// Purpose  : Multi-cycle CPU control unit: state register, sticky halt flag
//            and per-state datapath enable/select decode.
// Revision : 1.0  initial release
// ============================================================================
module mc_control_unit
    import mc_control_unit_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       halted,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegData,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [1:0] PCSrc
);

    state_t cur_state;
    state_t nxt_state;
    logic   halt_hit;

    assign state    = cur_state;
    assign halt_hit = (cur_state == ST_ID) && (Opcode == OP_HALT) && !halted;

    mc_next_state u_next_state (
        .state      (cur_state),
        .halted     (halted),
        .opcode     (Opcode),
        .next_state (nxt_state)
    );

    // State register and sticky halt flag; only reset clears the halt
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cur_state <= ST_IF;
            halted    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (halt_hit) begin
                halted <= 1'b1;
            end
        end
    end

    // Per-state output decode; reset and halt force every enable low
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = REGDST_RA;
        WrRegData = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = PCSRC_SEQ;
        if (!Reset && !halted) begin
            case (cur_state)
                ST_IF: IRWre = 1'b1;
                ST_ID: begin
                    case (Opcode)
                        OP_J: begin
                            PCWre = 1'b1;
                            PCSrc = PCSRC_JUMP;
                        end
                        OP_JAL: begin
                            PCWre     = 1'b1;
                            PCSrc     = PCSRC_JUMP;
                            RegWre    = 1'b1;
                            RegDst    = REGDST_RA;
                            WrRegData = 1'b0;
                        end
                        OP_JR: begin
                            PCWre = 1'b1;
                            PCSrc = PCSRC_RS;
                        end
                        OP_HALT: PCWre = 1'b0;
                        default: begin
                            // Anything that does not continue past decode is a NOP
                            if (!is_r_class(Opcode) && (Opcode != OP_BEQ) &&
                                (Opcode != OP_SW) && (Opcode != OP_LW)) begin
                                PCWre = 1'b1;
                            end
                        end
                    endcase
                end
                ST_EXE_R, ST_WB_R: begin
                    ALUOp   = alu_op_for(Opcode);
                    ALUSrcA = (Opcode == OP_SLL);
                    ALUSrcB = (Opcode == OP_ADDI) || (Opcode == OP_ORI);
                    ExtSel  = (Opcode != OP_ORI);
                    if (cur_state == ST_WB_R) begin
                        PCWre     = 1'b1;
                        RegWre    = 1'b1;
                        WrRegData = 1'b1;
                        RegDst    = ((Opcode == OP_ADDI) || (Opcode == OP_ORI)) ? REGDST_RT : REGDST_RD;
                    end
                end
                ST_EXE_BEQ: begin
                    ALUOp = ALU_SUB;
                    PCWre = 1'b1;
                    PCSrc = zero ? PCSRC_BRANCH : PCSRC_SEQ;
                end
                ST_MEM_ADDR, ST_MEM: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                    ALUOp   = ALU_ADD;
                    if (cur_state == ST_MEM) begin
                        if (Opcode == OP_LW) begin
                            mRD = 1'b1;
                        end else if (Opcode == OP_SW) begin
                            mWR   = 1'b1;
                            PCWre = 1'b1;
                        end
                    end
                end
                ST_WB_LW: begin
                    PCWre     = 1'b1;
                    RegWre    = 1'b1;
                    RegDst    = REGDST_RT;
                    WrRegData = 1'b1;
                    DBDataSrc = 1'b1;
                end
                default: IRWre = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_unit
// Purpose  : Self-checking bench for mc_control_unit; expected output words
//            are queued as stimulus is applied and popped each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_control_unit;

    localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_ADDI = 6'b000010;
    localparam logic [5:0] T_OR  = 6'b010000, T_AND = 6'b010001, T_ORI  = 6'b010010;
    localparam logic [5:0] T_SLL = 6'b011000, T_MOVE = 6'b100000, T_SLT = 6'b100111;
    localparam logic [5:0] T_SW  = 6'b110000, T_LW  = 6'b110001, T_BEQ  = 6'b110100;
    localparam logic [5:0] T_J   = 6'b111000, T_JR  = 6'b111001, T_JAL  = 6'b111010;
    localparam logic [5:0] T_HALT = 6'b111111, T_ILL = 6'b001111;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] Opcode;
    logic       zero;
    logic [2:0] state;
    logic       halted, PCWre, IRWre, RegWre, WrRegData, ALUSrcA, ALUSrcB;
    logic       ExtSel, mRD, mWR, DBDataSrc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    int n_checks = 0;
    int n_bad    = 0;

    string       tag_q[$];
    logic [20:0] exp_q[$];
    logic [20:0] dut_vec;

    always #5 CLK = ~CLK;

    mc_control_unit dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero),
        .state(state), .halted(halted), .PCWre(PCWre), .IRWre(IRWre),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegData(WrRegData),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
    );

    assign dut_vec = {state, halted, PCWre, IRWre, RegWre, RegDst, WrRegData,
                      ALUSrcA, ALUSrcB, ALUOp, ExtSel, mRD, mWR, DBDataSrc, PCSrc};

    // Reference model of the full output word for a given state and inputs
    function automatic logic [20:0] model(input logic [2:0] st, input logic hl,
                                          input logic rs, input logic [5:0] op,
                                          input logic z);
        logic pcw, irw, rgw, wrd, asa, asb, ext, rd, wr, dbs;
        logic [1:0] dst, pcs;
        logic [2:0] alu;
        {pcw, irw, rgw, wrd, asa, asb, ext, rd, wr, dbs} = '0;
        dst = 2'b00; pcs = 2'b00; alu = 3'b000;
        if (!rs && !hl) begin
            case (st)
                3'b000: irw = 1'b1;
                3'b001: begin
                    if (op == T_J)        begin pcw = 1'b1; pcs = 2'b11; end
                    else if (op == T_JAL) begin pcw = 1'b1; pcs = 2'b11; rgw = 1'b1; end
                    else if (op == T_JR)  begin pcw = 1'b1; pcs = 2'b10; end
                    else if (op == T_ILL) pcw = 1'b1;
                end
                3'b110, 3'b111: begin
                    if (op == T_SUB) alu = 3'b001;
                    else if (op == T_SLL) alu = 3'b010;
                    else if (op == T_OR || op == T_ORI) alu = 3'b011;
                    else if (op == T_AND) alu = 3'b100;
                    else if (op == T_SLT) alu = 3'b101;
                    asa = (op == T_SLL);
                    asb = (op == T_ADDI || op == T_ORI);
                    ext = (op != T_ORI);
                    if (st == 3'b111) begin
                        pcw = 1'b1; rgw = 1'b1; wrd = 1'b1;
                        dst = (op == T_ADDI || op == T_ORI) ? 2'b01 : 2'b10;
                    end
                end
                3'b101: begin alu = 3'b001; pcw = 1'b1; pcs = z ? 2'b01 : 2'b00; end
                3'b010: begin asb = 1'b1; ext = 1'b1; end
                3'b011: begin
                    asb = 1'b1; ext = 1'b1;
                    if (op == T_LW) rd = 1'b1;
                    if (op == T_SW) begin wr = 1'b1; pcw = 1'b1; end
                end
                3'b100: begin pcw = 1'b1; rgw = 1'b1; dst = 2'b01; wrd = 1'b1; dbs = 1'b1; end
                default: irw = 1'b0;
            endcase
        end
        return {st, hl, pcw, irw, rgw, dst, wrd, asa, asb, alu, ext, rd, wr, dbs, pcs};
    endfunction

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st, input logic hl,
                            input logic rs, input logic [5:0] op, input logic z);
        tag_q.push_back(tag);
        exp_q.push_back(model(st, hl, rs, op, z));
    endtask

    task automatic check_one();
        string       t;
        logic [20:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", dut_vec, ~dut_vec);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, dut_vec, e);
        end
    endtask

    // Compare each queued entry, advancing one cycle after every compare
    task automatic drain();
        while (exp_q.size() != 0) begin
            check_one();
            @(negedge CLK);
        end
    endtask

    // Entry: DUT in fetch, mid-cycle. Exit: next fetch cycle, mid-cycle.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                             input int n, input logic [17:0] seq);
        for (int i = 0; i < n; i++) begin
            push_exp($sformatf("%s.c%0d", tag, i), seq[i*3 +: 3], 1'b0, 1'b0, op, z);
        end
        Opcode = op;
        zero   = z;
        #1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset  = 1'b1;
        Opcode = T_ADD;
        zero   = 1'b0;
        @(negedge CLK);
        push_exp("reset1", 3'b000, 1'b0, 1'b1, Opcode, zero);
        check_one();
        @(negedge CLK);
        push_exp("reset2", 3'b000, 1'b0, 1'b1, Opcode, zero);
        check_one();
        Reset = 1'b0;

        run_instr("add",   T_ADD,  1'b0, 4, 18'o007610);
        run_instr("sub",   T_SUB,  1'b0, 4, 18'o007610);
        run_instr("addi",  T_ADDI, 1'b0, 4, 18'o007610);
        run_instr("ori",   T_ORI,  1'b0, 4, 18'o007610);
        run_instr("sll",   T_SLL,  1'b0, 4, 18'o007610);
        run_instr("slt",   T_SLT,  1'b0, 4, 18'o007610);
        run_instr("and",   T_AND,  1'b0, 4, 18'o007610);
        run_instr("move",  T_MOVE, 1'b0, 4, 18'o007610);
        run_instr("or",    T_OR,   1'b0, 4, 18'o007610);
        run_instr("lw",    T_LW,   1'b0, 5, 18'o043210);
        run_instr("sw",    T_SW,   1'b0, 4, 18'o003210);
        run_instr("beq_z1", T_BEQ, 1'b1, 3, 18'o000510);
        run_instr("beq_z0", T_BEQ, 1'b0, 3, 18'o000510);
        run_instr("j",     T_J,    1'b0, 2, 18'o000010);
        run_instr("jr",    T_JR,   1'b0, 2, 18'o000010);
        run_instr("jal",   T_JAL,  1'b0, 2, 18'o000010);
        run_instr("ill",   T_ILL,  1'b0, 2, 18'o000010);

        // halt: decode, then frozen in fetch with every enable low
        push_exp("halt.c0", 3'b000, 1'b0, 1'b0, T_HALT, 1'b0);
        push_exp("halt.c1", 3'b001, 1'b0, 1'b0, T_HALT, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push_exp($sformatf("halted.%0d", i), 3'b000, 1'b1, 1'b0, T_HALT, 1'b0);
        end
        Opcode = T_HALT;
        #1;
        drain();
        Opcode = T_ADD;
        Reset  = 1'b1;
        @(negedge CLK);
        push_exp("halt_clr", 3'b000, 1'b0, 1'b1, T_ADD, 1'b0);
        check_one();
        Reset = 1'b0;
        run_instr("add2", T_ADD, 1'b0, 4, 18'o007610);

        // sw aborted by reset while in the memory cycle
        push_exp("swr.c0", 3'b000, 1'b0, 1'b0, T_SW, 1'b0);
        push_exp("swr.c1", 3'b001, 1'b0, 1'b0, T_SW, 1'b0);
        push_exp("swr.c2", 3'b010, 1'b0, 1'b0, T_SW, 1'b0);
        Opcode = T_SW;
        #1;
        drain();
        push_exp("swr.mem", 3'b011, 1'b0, 1'b0, T_SW, 1'b0);
        check_one();
        Reset = 1'b1;
        push_exp("swr.rst_same", 3'b011, 1'b0, 1'b1, T_SW, 1'b0);
        #1;
        check_one();
        @(negedge CLK);
        push_exp("swr.rst_next", 3'b000, 1'b0, 1'b1, T_SW, 1'b0);
        check_one();
        Reset = 1'b0;
        run_instr("lw2", T_LW, 1'b0, 5, 18'o043210);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
